gain_mult_scheduler: RTL and testbench

GAIN_MULT_SCHEDULER -- requirements
Module: gain_mult_scheduler

---
 rtl/gain_mult_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_gain_mult_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gain_mult_scheduler.sv
// Schedules L+R and L-R gain products onto one shared sequential multiplier.
// Define GAIN_SCHED_ROUND_EN to round half up before the divide-by-8 scaling.
module gain_mult_scheduler #(
    parameter int TIMEOUT = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic signed [17:0] LEFT,
    input  logic signed [17:0] RIGHT,
    input  logic        [3:0]  Ks,
    input  logic        [3:0]  Kd,
    output logic               mult_start,
    output logic signed [17:0] mult_A,
    output logic signed [4:0]  mult_B,
    input  logic               mult_ready,
    input  logic signed [22:0] mult_R,
    output logic signed [17:0] LpR_out,
    output logic signed [17:0] LmR_out,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun,
    output logic               timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START_SUM = 3'd1,
        S_WAIT_SUM  = 3'd2,
        S_START_DIF = 3'd3,
        S_WAIT_DIF  = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t                   state_r;
    logic signed [17:0]       dif_r;
    logic        [3:0]        kd_r;
    logic                     ready_q_r;
    logic        [CNT_W-1:0]  wait_cnt_r;
    logic                     mult_start_r;
    logic signed [17:0]       mult_a_r;
    logic signed [4:0]        mult_b_r;
    logic signed [17:0]       lpr_r;
    logic signed [17:0]       lmr_r;
    logic                     out_valid_r;
    logic                     busy_r;
    logic                     overrun_r;
    logic                     timeout_err_r;

    logic signed [18:0]       sum_s;
    logic signed [18:0]       dif_s;
    logic                     ready_edge_s;

    // Clamp a 19-bit signed value into the 18-bit signed range.
    function automatic logic signed [17:0] sat19(input logic signed [18:0] v);
        logic signed [17:0] r;
        if (v > 19'sh1FFFF) begin
            r = 18'sh1FFFF;
        end else if (v < 19'sh60000) begin
            r = 18'sh20000;
        end else begin
            r = v[17:0];
        end
        return r;
    endfunction

    // Divide the product by 8 (arithmetic) and clamp to 18-bit signed.
    function automatic logic signed [17:0] scale(input logic signed [22:0] p);
        logic signed [23:0] w;
        logic signed [17:0] r;
        w = {p[22], p};
`ifdef GAIN_SCHED_ROUND_EN
        w = w + 24'sd4;
`endif
        w = w >>> 3;
        if (w > 24'sh01FFFF) begin
            r = 18'sh1FFFF;
        end else if (w < 24'shFE0000) begin
            r = 18'sh20000;
        end else begin
            r = w[17:0];
        end
        return r;
    endfunction

    // Sum/difference are formed one bit wider so overflow can be clamped.
    assign sum_s        = {LEFT[17], LEFT} + {RIGHT[17], RIGHT};
    assign dif_s        = {LEFT[17], LEFT} - {RIGHT[17], RIGHT};
    assign ready_edge_s = mult_ready & ~ready_q_r;

    assign mult_start  = mult_start_r;
    assign mult_A      = mult_a_r;
    assign mult_B      = mult_b_r;
    assign LpR_out     = lpr_r;
    assign LmR_out     = lmr_r;
    assign out_valid   = out_valid_r;
    assign busy        = busy_r;
    assign overrun     = overrun_r;
    assign timeout_err = timeout_err_r;

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= S_IDLE;
            dif_r         <= 18'sd0;
            kd_r          <= 4'd0;
            ready_q_r     <= 1'b0;
            wait_cnt_r    <= '0;
            mult_start_r  <= 1'b0;
            mult_a_r      <= 18'sd0;
            mult_b_r      <= 5'sd0;
            lpr_r         <= 18'sd0;
            lmr_r         <= 18'sd0;
            out_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            overrun_r     <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            ready_q_r <= mult_ready;
            if (sample_valid && (state_r != S_IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                S_IDLE: begin
                    if (sample_valid) begin
                        dif_r        <= sat19(dif_s);
                        kd_r         <= Kd;
                        mult_a_r     <= sat19(sum_s);
                        mult_b_r     <= {1'b0, Ks};
                        mult_start_r <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= S_START_SUM;
                    end
                end
                S_START_SUM: begin
                    mult_start_r <= 1'b0;
                    wait_cnt_r   <= '0;
                    state_r      <= S_WAIT_SUM;
                end
                S_WAIT_SUM: begin
                    if (ready_edge_s) begin
                        lpr_r        <= scale(mult_R);
                        mult_a_r     <= dif_r;
                        mult_b_r     <= {1'b0, kd_r};
                        mult_start_r <= 1'b1;
                        state_r      <= S_START_DIF;
                    end else if (wait_cnt_r == CNT_LAST) begin
                        timeout_err_r <= 1'b1;
                        busy_r        <= 1'b0;
                        state_r       <= S_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
                end
                S_START_DIF: begin
                    mult_start_r <= 1'b0;
                    wait_cnt_r   <= '0;
                    state_r      <= S_WAIT_DIF;
                end
                S_WAIT_DIF: begin
                    if (ready_edge_s) begin
                        lmr_r       <= scale(mult_R);
                        out_valid_r <= 1'b1;
                        state_r     <= S_DONE;
                    end else if (wait_cnt_r == CNT_LAST) begin
                        timeout_err_r <= 1'b1;
                        busy_r        <= 1'b0;
                        state_r       <= S_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= S_IDLE;
                end
                default: begin
                    mult_start_r <= 1'b0;
                    out_valid_r  <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gain_mult_scheduler.sv
// Directed bench for gain_mult_scheduler with a behavioural sequential multiplier.
`timescale 1ns/1ps
module tb_gain_mult_scheduler;

    logic               clock = 1'b0;
    logic               reset;
    logic               sample_valid;
    logic signed [17:0] LEFT;
    logic signed [17:0] RIGHT;
    logic        [3:0]  Ks;
    logic        [3:0]  Kd;
    logic               mult_start;
    logic signed [17:0] mult_A;
    logic signed [4:0]  mult_B;
    logic               mult_ready;
    logic signed [22:0] mult_R;
    logic signed [17:0] LpR_out;
    logic signed [17:0] LmR_out;
    logic               out_valid;
    logic               busy;
    logic               overrun;
    logic               timeout_err;

    int   checks   = 0;
    int   errors   = 0;
    int   ov_count = 0;
    int   mul_lat  = 3;
    logic mul_en   = 1'b1;
    int   ov0;
    int   exp_small;

    always #5 clock = ~clock;

    gain_mult_scheduler #(.TIMEOUT(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .LEFT         (LEFT),
        .RIGHT        (RIGHT),
        .Ks           (Ks),
        .Kd           (Kd),
        .mult_start   (mult_start),
        .mult_A       (mult_A),
        .mult_B       (mult_B),
        .mult_ready   (mult_ready),
        .mult_R       (mult_R),
        .LpR_out      (LpR_out),
        .LmR_out      (LmR_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Shared multiplier: ready drops on start, rises mul_lat cycles later.
    initial begin
        logic signed [22:0] prod;
        int                 cnt;
        bit                 pending;
        prod = 23'sd0;
        cnt = 0;
        pending = 1'b0;
        mult_ready = 1'b0;
        mult_R = 23'sd0;
        forever begin
            @(negedge clock);
            if (mult_start === 1'b1) begin
                mult_ready = 1'b0;
                prod = mult_A * mult_B;
                cnt = mul_lat;
                pending = 1'b1;
            end else if (pending) begin
                if (cnt > 1) begin
                    cnt--;
                end else if (mul_en) begin
                    mult_R = prod;
                    mult_ready = 1'b1;
                    pending = 1'b0;
                end
            end
        end
    end

    // Count out_valid pulses, sampled just after the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (out_valid === 1'b1) ov_count++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic drive_sample(input logic signed [17:0] l, input logic signed [17:0] r,
                                input logic [3:0] ks, input logic [3:0] kd);
        @(negedge clock);
        LEFT = l;
        RIGHT = r;
        Ks = ks;
        Kd = kd;
        sample_valid = 1'b1;
        @(posedge clock);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (mult_start !== 1'b1 && n < 200);
        check_eq({tag, "_start"}, int'(mult_start), 1);
    endtask

    task automatic wait_done(input string tag, input int elp, input int elm);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (out_valid !== 1'b1 && n < 300);
        check_eq({tag, "_valid"}, int'(out_valid), 1);
        check_eq({tag, "_lpr"}, int'(LpR_out), elp);
        check_eq({tag, "_lmr"}, int'(LmR_out), elm);
        @(negedge clock);
        check_eq({tag, "_valid_low"}, int'(out_valid), 0);
        check_eq({tag, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        reset = 1'b1;
        sample_valid = 1'b0;
        LEFT = 18'sd0;
        RIGHT = 18'sd0;
        Ks = 4'd0;
        Kd = 4'd0;
        repeat (3) @(negedge clock);
        check_eq("rst_lpr", int'(LpR_out), 0);
        check_eq("rst_lmr", int'(LmR_out), 0);
        check_eq("rst_valid", int'(out_valid), 0);
        check_eq("rst_start", int'(mult_start), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_overrun", int'(overrun), 0);
        check_eq("rst_timeout", int'(timeout_err), 0);
        reset = 1'b0;

        // Basic scaling
        ov0 = ov_count;
        drive_sample(18'sd1000, 18'sd500, 4'd8, 4'd8);
        wait_start("t1");
        check_eq("t1_multA", int'(mult_A), 1500);
        check_eq("t1_multB", int'(mult_B), 8);
        check_eq("t1_busy", int'(busy), 1);
        @(negedge clock);
        check_eq("t1_start_1cyc", int'(mult_start), 0);
        wait_done("t1", 1500, 500);
        check_eq("t1_pulses", ov_count - ov0, 1);

        // Positive saturation of the sum and of the scaled product
        drive_sample(18'sd100000, 18'sd100000, 4'd15, 4'd3);
        wait_start("t2");
        check_eq("t2_multA_sat", int'(mult_A), 131071);
        wait_done("t2", 131071, 0);

        // Small negative: truncation vs round-half-up
`ifdef GAIN_SCHED_ROUND_EN
        exp_small = 0;
`else
        exp_small = -1;
`endif
        drive_sample(-18'sd3, 18'sd0, 4'd1, 4'd1);
        wait_done("t3", exp_small, exp_small);

        // Negative saturation of the difference
        drive_sample(-18'sd100000, 18'sd100000, 4'd15, 4'd15);
        wait_done("t4", 0, -131072);

        // Overrun: second sample during WAIT_SUM is dropped
        check_eq("pre_overrun", int'(overrun), 0);
        ov0 = ov_count;
        drive_sample(18'sd2000, -18'sd1000, 4'd4, 4'd2);
        wait_start("ovr");
        @(negedge clock);
        LEFT = 18'sd8;
        RIGHT = 18'sd8;
        Ks = 4'd1;
        Kd = 4'd1;
        sample_valid = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
        check_eq("ovr_flag", int'(overrun), 1);
        wait_done("ovr", 500, 750);
        repeat (5) @(negedge clock);
        check_eq("ovr_pulses", ov_count - ov0, 1);
        check_eq("ovr_no_new_op", int'(busy), 0);

        // Timeout in WAIT_SUM
        mul_en = 1'b0;
        ov0 = ov_count;
        drive_sample(18'sd4000, 18'sd0, 4'd8, 4'd8);
        wait_start("to");
        repeat (64) @(negedge clock);
        check_eq("to_not_yet", int'(timeout_err), 0);
        check_eq("to_busy", int'(busy), 1);
        check_eq("to_multA_hold", int'(mult_A), 4000);
        @(negedge clock);
        check_eq("to_flag", int'(timeout_err), 1);
        check_eq("to_idle", int'(busy), 0);
        check_eq("to_lpr_kept", int'(LpR_out), 500);
        check_eq("to_lmr_kept", int'(LmR_out), 750);
        mul_en = 1'b1;
        repeat (4) @(negedge clock);
        check_eq("to_no_pulse", ov_count - ov0, 0);
        check_eq("to_overrun_sticky", int'(overrun), 1);

        // Reset in WAIT_DIF; the late ready edge lands in IDLE
        drive_sample(18'sd1000, 18'sd500, 4'd8, 4'd8);
        wait_start("rs_sum");
        wait_start("rs_dif");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        ov0 = ov_count;
        repeat (8) @(negedge clock);
        check_eq("rs_no_pulse", ov_count - ov0, 0);
        check_eq("rs_lpr", int'(LpR_out), 0);
        check_eq("rs_lmr", int'(LmR_out), 0);
        check_eq("rs_overrun", int'(overrun), 0);
        check_eq("rs_timeout", int'(timeout_err), 0);
        check_eq("rs_busy", int'(busy), 0);
        check_eq("rs_start", int'(mult_start), 0);
        check_eq("rs_multA", int'(mult_A), 0);
        check_eq("rs_multB", int'(mult_B), 0);

        // Normal operation after the reset
        drive_sample(-18'sd800, -18'sd1600, 4'd8, 4'd5);
        wait_done("post", -2400, 500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
